// File: rtl/operand_serializer_if.sv
// Operand/bit-stream bundle for operand_serializer: pair handshake in, framed bit pairs out.
// The slave modport is the serializer's view; master is the upstream/downstream side.
interface operand_serializer_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned IDX_W = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             a;
   logic             b;
   logic             bit_valid;
   logic             bit_first;
   logic             bit_last;
   logic [IDX_W-1:0] bit_idx;

   modport master (
      output in_valid,
      output op_a,
      output op_b,
      input  in_ready,
      input  a,
      input  b,
      input  bit_valid,
      input  bit_first,
      input  bit_last,
      input  bit_idx
   );

   modport slave (
      input  in_valid,
      input  op_a,
      input  op_b,
      output in_ready,
      output a,
      output b,
      output bit_valid,
      output bit_first,
      output bit_last,
      output bit_idx
   );
endinterface

// File: rtl/operand_serializer.sv
// Streams a WIDTH-bit operand pair LSB first, one bit pair per clock, with framing flags.
// Optional feature: define OPSER_STALL_EN to add a stall input that freezes shifting.
module operand_serializer #(
   parameter int unsigned WIDTH = 8
) (
   input logic clk,
   input logic rst,
`ifdef OPSER_STALL_EN
   input logic stall,
`endif
   operand_serializer_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   logic             state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic stalled;
   logic at_last;
   logic ready;
   logic handshake;

   // Stall only matters while shifting; an idle block always accepts.
`ifdef OPSER_STALL_EN
   assign stalled = (state_q == ST_SHIFT) && stall;
`else
   assign stalled = 1'b0;
`endif

   assign at_last   = (idx_q == LAST_IDX);
   assign ready     = !rst && ((state_q == ST_IDLE) || (at_last && !stalled));
   assign handshake = bus.in_valid && ready;

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      idx_d   = idx_q;
      if (handshake) begin
         state_d = ST_SHIFT;
         sa_d    = bus.op_a;
         sb_d    = bus.op_b;
         idx_d   = '0;
      end else if (state_q == ST_SHIFT) begin
         if (!stalled) begin
            if (at_last) begin
               state_d = ST_IDLE;
               sa_d    = '0;
               sb_d    = '0;
               idx_d   = '0;
            end else begin
               sa_d  = {1'b0, sa_q[WIDTH-1:1]};
               sb_d  = {1'b0, sb_q[WIDTH-1:1]};
               idx_d = idx_q + IDX_W'(1);
            end
         end
      end else begin
         sa_d  = '0;
         sb_d  = '0;
         idx_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.a         = sa_q[0];
   assign bus.b         = sb_q[0];
   assign bus.bit_valid = (state_q == ST_SHIFT);
   assign bus.bit_first = (state_q == ST_SHIFT) && (idx_q == '0);
   assign bus.bit_last  = (state_q == ST_SHIFT) && at_last;
   assign bus.bit_idx   = idx_q;

endmodule

// File: tb/tb_operand_serializer.sv
// Self-checking bench for operand_serializer: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_operand_serializer;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stall = 1'b0;

   operand_serializer_if #(.WIDTH(W)) bus ();

   operand_serializer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
`ifdef OPSER_STALL_EN
      .stall (stall),
`endif
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a pair accepted at edge k presents bit i between edges k+i and k+i+1.
   logic         m_busy = 1'b0;
   int           m_pos  = 0;
   logic [W-1:0] m_a    = '0;
   logic [W-1:0] m_b    = '0;
   logic         check_en = 1'b0;

   function automatic logic stall_eff();
`ifdef OPSER_STALL_EN
      return stall;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic model_ready();
      return !rst && (!m_busy || (m_pos == W - 1 && !stall_eff()));
   endfunction

   always @(posedge clk) begin
      check_en <= 1'b1;
      if (rst) begin
         m_busy = 1'b0;
         m_pos  = 0;
      end else if (bus.in_valid && model_ready()) begin
         m_busy = 1'b1;
         m_pos  = 0;
         m_a    = bus.op_a;
         m_b    = bus.op_b;
      end else if (m_busy && !stall_eff()) begin
         if (m_pos == W - 1) m_busy = 1'b0;
         else m_pos = m_pos + 1;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("in_ready",  bus.in_ready,  model_ready());
         chk("a",         bus.a,         m_busy ? m_a[m_pos] : 1'b0);
         chk("b",         bus.b,         m_busy ? m_b[m_pos] : 1'b0);
         chk("bit_valid", bus.bit_valid, m_busy);
         chk("bit_first", bus.bit_first, m_busy && m_pos == 0);
         chk("bit_last",  bus.bit_last,  m_busy && m_pos == W - 1);
         chk("bit_idx",   bus.bit_idx,   m_busy ? m_pos : 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int lit_a [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
   int lit_b [8] = '{0, 0, 1, 1, 1, 1, 0, 0};

   initial begin
      logic pending;
      logic acc;
      int   run;

      bus.in_valid = 1'b1;
      bus.op_a     = 8'h77;
      bus.op_b     = 8'h11;

      // Reset held two cycles with in_valid high: nothing loads.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", bus.in_ready, 1);
      chk("rst_release_valid", bus.bit_valid, 0);

      // Single pair A5/3C.
      bus.op_a = 8'hA5;
      bus.op_b = 8'h3C;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("single_a", bus.a, lit_a[i]);
         chk("single_b", bus.b, lit_b[i]);
         chk("single_first", bus.bit_first, (i == 0));
         chk("single_last", bus.bit_last, (i == 7));
         step();
      end
      @(negedge clk);
      chk("single_idle_valid", bus.bit_valid, 0);
      chk("single_idle_ab", {bus.a, bus.b}, 0);

      // Back-to-back FF/00 then 01/80 with in_valid held.
      step();
      bus.op_a = 8'hFF;
      bus.op_b = 8'h00;
      bus.in_valid = 1'b1;
      step();
      bus.op_a = 8'h01;
      bus.op_b = 8'h80;
      run = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.bit_valid) run++;
         if (i == 7) chk("b2b_ready_at_7", bus.in_ready, 1);
         if (i >= 8) begin
            chk("b2b_a2", bus.a, (i == 8));
            chk("b2b_b2", bus.b, (i == 15));
         end
         step();
         if (i == 7) bus.in_valid = 1'b0;
      end
      chk("b2b_valid_run", run, 16);

      // Idle for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ready", bus.in_ready, 1);
         step();
      end

      // Reset at bit_idx 3.
      bus.op_a = 8'hA5;
      bus.op_b = 8'h3C;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      step();
      @(negedge clk);
      chk("midrst_idx3", bus.bit_idx, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", bus.bit_valid, 0);
      chk("midrst_ab", {bus.a, bus.b}, 0);
      bus.op_a = 8'h5A;
      bus.op_b = 8'hC3;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("postrst_bit0", {bus.a, bus.b}, 2'b01);
      repeat (9) step();

`ifdef OPSER_STALL_EN
      // Stall two cycles at bit 4 of A5.
      bus.op_a = 8'hA5;
      bus.op_b = 8'h00;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (4) step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_idx", bus.bit_idx, 4);
         chk("stall_a", bus.a, 0);
         chk("stall_ready", bus.in_ready, 0);
         step();
         if (i == 1) stall = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_resume", bus.a, lit_a[5 + i]);
         step();
      end
      repeat (2) step();
`endif

      // Randomized traffic; the source holds valid/data until accepted.
      pending = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (!pending && $urandom_range(0, 2) != 0) begin
            pending = 1'b1;
            bus.in_valid = 1'b1;
            bus.op_a = W'($urandom);
            bus.op_b = W'($urandom);
         end
`ifdef OPSER_STALL_EN
         stall = ($urandom_range(0, 3) == 0);
`endif
         rst = ($urandom_range(0, 99) == 0);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         step();
         if (acc || rst) begin
            pending = 1'b0;
            bus.in_valid = 1'b0;
         end
      end
      rst = 1'b0;
      stall = 1'b0;
      bus.in_valid = 1'b0;
      repeat (12) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
